// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
// Issues one operation at a time to an external ALU datapath. It waits a
// fixed latency (add/sub/and/or/mul) or for a divider strobe (div). Then it
// holds the captured result until the consumer accepts it.
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_opcode, req_a/b     operation and operands
//   alu_a/b, alu_opcode     registered operands/opcode driven to the ALU
//   alu_result, alu_zero    ALU result and zero flag
//   div_ready               divider completion strobe
//   rsp_valid/rsp_ready     response handshake
//   rsp_result/zero/error   captured response
//   busy                    high whenever not idle
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int unsigned MUL_LAT     = 4,
   parameter int unsigned DIV_TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [3:0]    req_opcode,
   input  logic [63:0]   req_a,
   input  logic [63:0]   req_b,
   output logic [63:0]   alu_a,
   output logic [63:0]   alu_b,
   output logic [3:0]    alu_opcode,
   input  logic [127:0]  alu_result,
   input  logic          alu_zero,
   input  logic          div_ready,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [127:0]  rsp_result,
   output logic          rsp_zero,
   output logic          rsp_error,
   output logic          busy
);

   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [7:0]  cnt;
   logic [7:0]  cnt_load;
   logic        legal;
   logic        is_div;
   logic        accept;
   logic        capture;
   logic        fail;

   always_comb begin
      legal    = 1'b0;
      cnt_load = '0;
      case (req_opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR: legal = 1'b1;
         OP_MUL: begin
            legal    = 1'b1;
            cnt_load = 8'(MUL_LAT - 1);
         end
         OP_DIV: begin
            legal    = 1'b1;
            cnt_load = 8'(DIV_TIMEOUT - 1);
         end
         default: legal = 1'b0;
      endcase
   end

   // alu_opcode is held for the whole WAIT, so it identifies the op in flight.
   assign is_div = (alu_opcode == OP_DIV);

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      capture    = 1'b0;
      fail       = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (legal) begin
                  accept     = 1'b1;
                  state_next = WAIT;
               end else begin
                  fail       = 1'b1;
                  state_next = DONE;
               end
            end
         end
         WAIT: begin
            // On the timeout edge a divider strobe still wins.
            if (is_div) begin
               if (div_ready) begin
                  capture = 1'b1;
               end else if (cnt == '0) begin
                  fail = 1'b1;
               end
            end else if (cnt == '0) begin
               capture = 1'b1;
            end
            if (capture || fail) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_error  <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_opcode <= req_opcode;
            cnt        <= cnt_load;
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 8'd1;
         end
         if (capture) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_error  <= 1'b0;
         end else if (fail) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_error  <= 1'b1;
         end
      end
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule
